div_seq: RTL
============

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have a single clock; reset is synchronous and active-high.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 start  in  1  E-stage DIV/DIVU issue; held high by the pipeline while stalled.
REQ-005 signed_div  in  1  1 = DIV (two's complement), 0 = DIVU.
REQ-006 annul  in  1  flush/exception; cancels any issue or division in flight.
REQ-007 opdata1  in  32  dividend (rs).
REQ-008 opdata2  in  32  divisor (rt).
REQ-009 result  out  64  {hi = remainder, lo = quotient}.
REQ-010 ready  out  1  one-cycle pulse; result valid this cycle.
REQ-011 stall  out  1  freeze F/D/E stages while high.

Function
REQ-012 FSM SHALL have states IDLE, ZERO, ON, END.
REQ-013 IDLE: start=1 and annul=0 SHALL latch operands and signed_div.
- Latched operands are converted to magnitudes when signed.
- Clear cnt, go to ON.
- Under DIV_ZERO_FAST_EN with opdata2==0, go to ZERO instead.
REQ-014 ON SHALL perform one restoring shift-subtract iteration per cycle on a 65-bit partial remainder; cnt 0..31.
REQ-015 ON with cnt==31 SHALL go to END after that iteration.
REQ-016 END SHALL apply sign fixups, drive result, assert ready for exactly one cycle, then return to IDLE.
- Sign fixups apply only when signed.
- Quotient is negated when the operand signs differ.
- Remainder takes the dividend's sign.
REQ-017 Latency: start seen in cycle 0 -> ON cycles 1..32 -> ready in cycle 33.
REQ-018 stall SHALL be 1 in IDLE when start=1 and annul=0.
REQ-019 stall SHALL be 1 in ZERO and in ON.
REQ-020 stall SHALL be 0 in END and in all other cases, so the pipeline advances in the ready cycle.
REQ-021 start SHALL be ignored outside IDLE; start in the cycle after END is a new instruction.
REQ-022 annul=1 in IDLE SHALL suppress acceptance.
REQ-023 annul=1 in ZERO or ON SHALL go to IDLE next cycle with no ready pulse; stall drops in that same cycle.
REQ-024 annul=1 in END SHALL still complete the ready pulse; the pipeline discards it.
REQ-025 result SHALL hold its value after ready until the next END.
REQ-026 The signed edge case 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0 with no trap.
REQ-027 Arithmetic SHALL be modulo 2^32; magnitude of 0x80000000 is held as unsigned 0x80000000.

Reset
REQ-028 rst=1 SHALL force the following at the next edge, overriding every other input:
- state=IDLE, cnt=0.
- result=64'h0, ready=0.
- partial remainder cleared.
REQ-029 stall SHALL be 0 while rst=1.
REQ-030 Reset mid-division SHALL abandon the division with no ready pulse.

Configuration
REQ-031 Macro DIV_ZERO_FAST_EN SHALL enable the ZERO state.
REQ-032 With DIV_ZERO_FAST_EN defined, a zero divisor SHALL complete as follows:
- Path is IDLE -> ZERO (cycle 1) -> END (cycle 2, ready).
- result = {hi=opdata1, lo=32'hFFFF_FFFF}; no sign fixup.
REQ-033 With DIV_ZERO_FAST_EN undefined, ZERO SHALL not exist and a zero divisor SHALL run the full 32 iterations.
- DIVU result: lo=0xFFFFFFFF, hi=dividend.
- DIV result: unchecked (MIPS-undefined).

Verification
REQ-034 DIVU 100/7, start held -> stall high cycles 0..32; ready in cycle 33 with lo=14, hi=2.
REQ-035 DIV -7/2 -> ready in cycle 33 with lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-036 DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 DIVU 50/5 with annul=1 in cycle 10 -> no ready, stall=0 in cycle 10; DIVU 9/3 started in cycle 11 -> ready in cycle 44, lo=3, hi=0.
REQ-038 DIVU 5/0 with DIV_ZERO_FAST_EN -> ready in cycle 2, lo=0xFFFFFFFF, hi=5; without it -> ready in cycle 33, same values.
REQ-039 rst=1 in cycle 20 of a division -> cycle 21: stall=0, ready=0, result=0; new DIVU 8/2 -> lo=4, hi=0.

Source files
------------

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
// Module   : div_seq
// Purpose  : Sequential 32-bit restoring divider for the E stage (DIV/DIVU).
//            One shift-subtract iteration per cycle over a 65-bit partial
//            remainder. The result appears 33 cycles after issue.
//            Result packing is {hi = remainder, lo = quotient}.
// Ports    : clk         system clock, rising edge
//            rst         synchronous active-high reset
//            start       issue request, held high while the pipeline stalls
//            signed_div  1 = DIV (two's complement), 0 = DIVU
//            annul       flush; cancels an issue or a division in flight
//            opdata1     dividend (rs)
//            opdata2     divisor (rt)
//            result      {hi, lo}; holds its value until the next completion
//            ready       one-cycle completion pulse
//            stall       freeze F/D/E while high
// Config   : DIV_ZERO_FAST_EN -- a zero divisor completes in 2 cycles through
//            the ZERO state instead of running all 32 iterations.
// Revision : 1.0 - initial release
// ============================================================================
module div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic        annul,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    output logic [63:0] result,
    output logic        ready,
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef DIV_ZERO_FAST_EN
        ZERO = 2'd1,
`endif
        ON   = 2'd2,
        END  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [64:0] r_part;      // {remainder, dividend bits / quotient bits}
    logic [31:0] r_divisor;   // divisor magnitude
    logic [4:0]  r_cnt;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [63:0] r_result;

    logic        w_accept;
    logic [31:0] w_dividend_mag;
    logic [31:0] w_divisor_mag;
    logic [64:0] w_shift;
    logic [32:0] w_diff;
    logic [64:0] w_iter;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;
    logic        w_last;

    assign w_accept = (r_state == IDLE) && start && !annul;
    assign w_last   = (r_cnt == 5'd31);

    // Negating 0x80000000 yields 0x80000000, which is its correct unsigned magnitude.
    assign w_dividend_mag = (signed_div && opdata1[31]) ? (32'd0 - opdata1) : opdata1;
    assign w_divisor_mag  = (signed_div && opdata2[31]) ? (32'd0 - opdata2) : opdata2;

    // One restoring step: shift left, trial-subtract the divisor from the upper
    // 33 bits, keep the difference and set the quotient bit when it is non-negative.
    assign w_shift = r_part << 1;
    assign w_diff  = w_shift[64:32] - {1'b0, r_divisor};
    assign w_iter  = w_diff[32] ? w_shift : {w_diff, w_shift[31:1], 1'b1};

    assign w_quot     = w_iter[31:0];
    assign w_rem      = w_iter[63:32];
    assign w_quot_fix = r_neg_q ? (32'd0 - w_quot) : w_quot;
    assign w_rem_fix  = r_neg_r ? (32'd0 - w_rem)  : w_rem;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and stall
    // ------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        stall  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    stall  = 1'b1;
                    w_next = ON;
`ifdef DIV_ZERO_FAST_EN
                    if (opdata2 == 32'd0) begin
                        w_next = ZERO;
                    end
`endif
                end
            end
`ifdef DIV_ZERO_FAST_EN
            ZERO: begin
                if (annul) begin
                    w_next = IDLE;
                end else begin
                    stall  = 1'b1;
                    w_next = END;
                end
            end
`endif
            ON: begin
                if (annul) begin
                    w_next = IDLE;
                end else begin
                    stall = 1'b1;
                    if (w_last) begin
                        w_next = END;
                    end
                end
            end
            END: begin
                // start is ignored here; the pipeline advances this cycle.
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
        if (rst) begin
            stall = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_part    <= 65'd0;
            r_divisor <= 32'd0;
            r_cnt     <= 5'd0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result  <= 64'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cnt     <= 5'd0;
                        r_divisor <= w_divisor_mag;
                        r_neg_q   <= signed_div && (opdata1[31] ^ opdata2[31]);
                        r_neg_r   <= signed_div && opdata1[31];
                        r_part    <= {33'd0, w_dividend_mag};
`ifdef DIV_ZERO_FAST_EN
                        // Pre-build the final {hi, lo} so ZERO only copies it out.
                        if (opdata2 == 32'd0) begin
                            r_part  <= {1'b0, opdata1, 32'hFFFF_FFFF};
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end
`endif
                    end
                end
`ifdef DIV_ZERO_FAST_EN
                ZERO: begin
                    if (!annul) begin
                        r_result <= r_part[63:0];
                    end
                end
`endif
                ON: begin
                    if (!annul) begin
                        r_part <= w_iter;
                        r_cnt  <= r_cnt + 5'd1;
                        // Sign fixups are folded into the load so result is
                        // already valid in the END cycle.
                        if (w_last) begin
                            r_result <= {w_rem_fix, w_quot_fix};
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_result;
    assign ready  = (r_state == END);

endmodule
`default_nettype wire
